// File: rtl/multicore_pkg.sv
// Shared types for the multicore pipeline: hazard-controller FSM states and
// forward-select encodings used by hazard_ctrl and hz_fwd_sel.
package multicore_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } hz_state_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MA   = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

endpackage

// File: rtl/hz_fwd_sel.sv
// Forward-select priority for one source port: MA result wins over WB, and
// x0 never forwards because it is hard-wired to zero in the register file.
module hz_fwd_sel
    import multicore_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic [RW-1:0] i_rs,
    input  logic          i_ma_regwrite,
    input  logic [RW-1:0] i_ma_rdest,
    input  logic          i_wb_regwrite,
    input  logic [RW-1:0] i_wb_rdest,
    output logic [1:0]    o_sel
);

    always_comb begin
        o_sel = FWD_NONE;
        if (i_rs != '0) begin
            if (i_ma_regwrite && (i_ma_rdest == i_rs)) begin
                o_sel = FWD_MA;
            end else if (i_wb_regwrite && (i_wb_rdest == i_rs)) begin
                o_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the IF/ID/EX/MA/WB pipeline: stage enables, flushes,
// forward selects, fetch redirect, memory-stall watchdog and perf counters.
module hazard_ctrl
    import multicore_pkg::*;
#(
    parameter int   NUM_REGS      = 32,
    parameter int   NUM_SRC       = 2,
    parameter int   FLUSH_SHADOW  = 0,
    parameter int   STALL_TIMEOUT = 1024,
    parameter int   CNT_W         = 32,
    localparam int  RW            = $clog2(NUM_REGS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_fetch_instr_valid,
    input  logic                    i_decode_br_valid,
    input  logic [31:0]             i_decode_br_addr,
    input  logic [31:0]             i_decode_pc,
    input  logic [NUM_SRC*RW-1:0]   i_decode_rs,
    input  logic [NUM_SRC-1:0]      i_decode_rs_used,
    input  logic                    i_execute_br_valid,
    input  logic [31:0]             i_execute_br_addr,
    input  logic [NUM_SRC*RW-1:0]   i_exe_rs,
    input  logic                    i_exe_memread,
    input  logic [RW-1:0]           i_exe_rdest,
    input  logic                    i_ma_cache_ready,
    input  logic                    i_ma_memaccess,
    input  logic                    i_ma_regwrite,
    input  logic [RW-1:0]           i_ma_rdest,
    input  logic                    i_wb_regwrite,
    input  logic [RW-1:0]           i_wb_rdest,
    output logic                    o_br_valid,
    output logic [31:0]             o_br_addr,
    output logic                    o_fetch_en,
    output logic                    o_decode_en,
    output logic                    o_exe_en,
    output logic                    o_ma_en,
    output logic                    o_decode_flush,
    output logic                    o_exe_flush,
    output logic [NUM_SRC*2-1:0]    o_decode_fwd,
    output logic [NUM_SRC*2-1:0]    o_exe_fwd,
    output logic                    o_stall_timeout,
    output logic [1:0]              o_state,
    output logic [CNT_W-1:0]        o_cnt_ld_stall,
    output logic [CNT_W-1:0]        o_cnt_mem_stall,
    output logic [CNT_W-1:0]        o_cnt_flush
);

    localparam int             WD_W   = $clog2(STALL_TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT - 1);
    localparam logic [2:0]     SHADOW_LOAD = 3'(FLUSH_SHADOW);

    hz_state_e         state_q, state_d;
    logic [2:0]        shadow_q, shadow_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_ld_q, cnt_ld_d;
    logic [CNT_W-1:0]  cnt_mem_q, cnt_mem_d;
    logic [CNT_W-1:0]  cnt_flush_q, cnt_flush_d;

    logic mstall, mispred, ldu, mis_act, ld_stall, front_en;

    // Hazard classification; mstall dominates, a mispredict dominates ldu.
    always_comb begin
        mstall  = i_ma_memaccess & ~i_ma_cache_ready;
        mispred = i_execute_br_valid & (i_decode_pc != i_execute_br_addr);
        ldu     = 1'b0;
        for (int p = 0; p < NUM_SRC; p++) begin
            if (i_decode_rs_used[p] && (i_decode_rs[p*RW +: RW] == i_exe_rdest)) begin
                ldu = 1'b1;
            end
        end
        ldu      = ldu & i_exe_memread & (i_exe_rdest != '0);
        mis_act  = mispred & ~mstall;
        ld_stall = ldu & ~mispred & ~mstall;
        front_en = ~mstall & ~ld_stall;
    end

    assign o_fetch_en     = front_en;
    assign o_decode_en    = front_en;
    assign o_exe_en       = ~mstall;
    assign o_ma_en        = ~mstall;
    assign o_exe_flush    = mis_act | ld_stall;
    assign o_br_valid     = (i_execute_br_valid | i_decode_br_valid) & front_en;
    assign o_br_addr      = i_execute_br_valid ? i_execute_br_addr : i_decode_br_addr;
    assign o_decode_flush = ~mstall & (~i_fetch_instr_valid | o_br_valid | (shadow_q != '0));

    for (genvar p = 0; p < NUM_SRC; p++) begin : g_fwd
        hz_fwd_sel #(.RW(RW)) u_dec_sel (
            .i_rs          (i_decode_rs[p*RW +: RW]),
            .i_ma_regwrite (i_ma_regwrite),
            .i_ma_rdest    (i_ma_rdest),
            .i_wb_regwrite (i_wb_regwrite),
            .i_wb_rdest    (i_wb_rdest),
            .o_sel         (o_decode_fwd[p*2 +: 2])
        );
        hz_fwd_sel #(.RW(RW)) u_exe_sel (
            .i_rs          (i_exe_rs[p*RW +: RW]),
            .i_ma_regwrite (i_ma_regwrite),
            .i_ma_rdest    (i_ma_rdest),
            .i_wb_regwrite (i_wb_regwrite),
            .i_wb_rdest    (i_wb_rdest),
            .o_sel         (o_exe_fwd[p*2 +: 2])
        );
    end

    always_comb begin
        shadow_d = shadow_q;
        if (mis_act) begin
            shadow_d = SHADOW_LOAD;
        end else if (front_en && (shadow_q != '0)) begin
            shadow_d = shadow_q - 3'd1;
        end

        if (mstall) begin
            state_d = MEM_WAIT;
        end else if (mispred || (shadow_q != '0)) begin
            state_d = FLUSH;
        end else if (ldu) begin
            state_d = LD_STALL;
        end else begin
            state_d = RUN;
        end

        wd_d = '0;
        if (mstall) begin
            wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
        end
        timeout_d = timeout_q | (mstall & (wd_q == WD_MAX));

        cnt_ld_d    = (ld_stall && (cnt_ld_q != '1))    ? cnt_ld_q + CNT_W'(1)    : cnt_ld_q;
        cnt_mem_d   = (mstall && (cnt_mem_q != '1))     ? cnt_mem_q + CNT_W'(1)   : cnt_mem_q;
        cnt_flush_d = (mis_act && (cnt_flush_q != '1))  ? cnt_flush_q + CNT_W'(1) : cnt_flush_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= RUN;
            shadow_q    <= '0;
            wd_q        <= '0;
            timeout_q   <= 1'b0;
            cnt_ld_q    <= '0;
            cnt_mem_q   <= '0;
            cnt_flush_q <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
            cnt_ld_q    <= cnt_ld_d;
            cnt_mem_q   <= cnt_mem_d;
            cnt_flush_q <= cnt_flush_d;
        end
    end

    assign o_state         = state_q;
    assign o_stall_timeout = timeout_q;
    assign o_cnt_ld_stall  = cnt_ld_q;
    assign o_cnt_mem_stall = cnt_mem_q;
    assign o_cnt_flush     = cnt_flush_q;

endmodule
